// File: rtl/sort_pkg.sv
// Shared sorting-path constants and the stream FSM state encoding.
package sort_pkg;

  localparam int SORT_DATA_W    = 32;
  localparam int SORT_FRAME_LEN = 10;
  localparam int SORT_CNT_W     = 4;
  localparam int SORT_BUF_DEPTH = 2;

  // Encoding is shared with the sorter; keep the values fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stream_state_t;

endpackage

// File: rtl/axis_out_buf.sv
// Small circular register buffer holding words between the result FIFO read
// port and the AXI-stream output. Head is read straight from storage.
module axis_out_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [OCC_W-1:0]  occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; simultaneous push and pop keep occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sort_result_streamer.sv
// Drains FRAME_LEN sorted words from the result FIFO and emits them as one
// AXI-stream frame with sm_tlast on the final word.
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int DATA_W    = SORT_DATA_W,
  parameter int FRAME_LEN = SORT_FRAME_LEN,
  parameter int CNT_W     = SORT_CNT_W,
  parameter int BUF_DEPTH = SORT_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start_stream,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic              busy,
  output logic              done_stream
);

  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int PEND_W = OCC_W + 1;

  stream_state_t     state;
  stream_state_t     state_next;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic              inflight;
  logic [OCC_W-1:0]  occ;
  logic              pop;
  logic              last_beat;
  logic [PEND_W-1:0] pending;

  axis_out_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .OCC_W  (OCC_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (sm_tdata),
    .occ       (occ)
  );

  assign sm_tvalid = (occ != '0);
  assign pop       = sm_tvalid && sm_tready;
  assign sm_tlast  = sm_tvalid && (tx_cnt == CNT_W'(FRAME_LEN - 1));
  assign last_beat = pop && sm_tlast;

  // Buffer slots already claimed once this cycle settles: stored words plus the
  // read in flight, minus the beat leaving now. A new read needs a free slot.
  assign pending    = PEND_W'(occ) + PEND_W'(inflight) - PEND_W'(pop);
  assign fifo_rd_en = (state == ST_RUN) && !fifo_empty &&
                      (rd_cnt < CNT_W'(FRAME_LEN)) &&
                      (pending < PEND_W'(BUF_DEPTH));

  // Next-state and status decode.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    done_stream = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start_stream) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_beat) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done_stream = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, word counters and read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      if (state == ST_DONE) begin
        rd_cnt <= '0;
      end else if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (pop) begin
        tx_cnt <= last_beat ? '0 : tx_cnt + 1'b1;
      end
    end
  end

endmodule
